// File: rtl/tt_um_emern_vga_timing_p.sv
// VGA-style raster timing generator: pixel/line counters, sync and active decode with a
// tick-enabled delay line that matches pixel-path latency, plus frame and vblank pulses.
module tt_um_emern_vga_timing_p #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter logic        HS_POL     = 1'b0,
  parameter logic        VS_POL     = 1'b0,
  parameter int unsigned PIPE_DEPTH = 2,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned FRAME_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [CNT_W-1:0]   col_counter,
  output logic [CNT_W-1:0]   row_counter,
  output logic               h_sync,
  output logic               v_sync,
  output logic               active_video,
  output logic               screen_inactive,
  output logic               frame_start,
  output logic               vblank_irq,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (longint'(H_TOTAL) > (longint'(1) << CNT_W)) begin : g_bad_h_total
    $error("H_TOTAL does not fit in CNT_W bits");
  end
  if (longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_bad_v_total
    $error("V_TOTAL does not fit in CNT_W bits");
  end
  if (PIPE_DEPTH > 7) begin : g_bad_pipe_depth
    $error("PIPE_DEPTH must be in 0..7");
  end

  localparam logic [CNT_W-1:0] HLast   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VLast   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HActive = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VActive = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HsStart = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HsEnd   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VsStart = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VsEnd   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0]   col_q, col_d, row_q, row_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               frame_start_q, frame_start_d;
  logic               vblank_q, vblank_d;

  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    frame_d       = frame_q;
    frame_start_d = 1'b0;
    vblank_d      = 1'b0;
    if (en) begin
      if (col_q == HLast) begin
        col_d = '0;
        if (row_q == VLast) begin
          row_d         = '0;
          frame_d       = frame_q + 1'b1;
          frame_start_d = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
        vblank_d = (row_d == VActive);
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q         <= '0;
      row_q         <= '0;
      frame_q       <= '0;
      frame_start_q <= 1'b0;
      vblank_q      <= 1'b0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      frame_q       <= frame_d;
      frame_start_q <= frame_start_d;
      vblank_q      <= vblank_d;
    end
  end

  // Undelayed decode, already at output polarity.
  logic hs_now, vs_now, act_now;

  always_comb begin
    hs_now  = ((col_q >= HsStart) && (col_q <= HsEnd)) ? HS_POL : ~HS_POL;
    vs_now  = ((row_q >= VsStart) && (row_q <= VsEnd)) ? VS_POL : ~VS_POL;
    act_now = (col_q < HActive) && (row_q < VActive);
  end

  if (PIPE_DEPTH == 0) begin : g_no_pipe
    assign h_sync       = hs_now;
    assign v_sync       = vs_now;
    assign active_video = act_now;
  end else begin : g_pipe
    logic [PIPE_DEPTH-1:0] hs_q, hs_d, vs_q, vs_d, act_q, act_d;

    always_comb begin
      hs_d  = hs_q;
      vs_d  = vs_q;
      act_d = act_q;
      if (en) begin
        hs_d[0]  = hs_now;
        vs_d[0]  = vs_now;
        act_d[0] = act_now;
        for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
          hs_d[i]  = hs_q[i-1];
          vs_d[i]  = vs_q[i-1];
          act_d[i] = act_q[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        hs_q  <= {PIPE_DEPTH{~HS_POL}};
        vs_q  <= {PIPE_DEPTH{~VS_POL}};
        act_q <= '0;
      end else begin
        hs_q  <= hs_d;
        vs_q  <= vs_d;
        act_q <= act_d;
      end
    end

    assign h_sync       = hs_q[PIPE_DEPTH-1];
    assign v_sync       = vs_q[PIPE_DEPTH-1];
    assign active_video = act_q[PIPE_DEPTH-1];
  end

  assign col_counter     = col_q;
  assign row_counter     = row_q;
  assign screen_inactive = (row_q >= VActive);
  assign frame_start     = frame_start_q;
  assign vblank_irq      = vblank_q;
  assign frame_count     = frame_q;

endmodule

// File: tb/tb_tt_um_emern_vga_timing_p.sv
// Bench for tt_um_emern_vga_timing_p: three configurations driven by shared random rst/en and
// compared every cycle against an arithmetic model based on the count of enabled ticks.
module tb_tt_um_emern_vga_timing_p;

  logic clk = 1'b0;
  logic rst, en;

  always #5 clk = ~clk;

  // A: defaults. B: tiny, no delay, active-high hsync, 2-bit frames. C: tiny, 3-stage delay.
  logic [9:0] col_a, row_a;
  logic [7:0] fc_a;
  logic       hs_a, vs_a, act_a, si_a, fs_a, vb_a;
  logic [4:0] col_b, row_b;
  logic [1:0] fc_b;
  logic       hs_b, vs_b, act_b, si_b, fs_b, vb_b;
  logic [3:0] col_c, row_c;
  logic [2:0] fc_c;
  logic       hs_c, vs_c, act_c, si_c, fs_c, vb_c;

  tt_um_emern_vga_timing_p u_dut_a (
    .clk(clk), .rst(rst), .en(en), .col_counter(col_a), .row_counter(row_a),
    .h_sync(hs_a), .v_sync(vs_a), .active_video(act_a), .screen_inactive(si_a),
    .frame_start(fs_a), .vblank_irq(vb_a), .frame_count(fc_a)
  );

  tt_um_emern_vga_timing_p #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .PIPE_DEPTH(0), .CNT_W(5), .FRAME_W(2)
  ) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .col_counter(col_b), .row_counter(row_b),
    .h_sync(hs_b), .v_sync(vs_b), .active_video(act_b), .screen_inactive(si_b),
    .frame_start(fs_b), .vblank_irq(vb_b), .frame_count(fc_b)
  );

  tt_um_emern_vga_timing_p #(
    .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b1), .PIPE_DEPTH(3), .CNT_W(4), .FRAME_W(3)
  ) u_dut_c (
    .clk(clk), .rst(rst), .en(en), .col_counter(col_c), .row_counter(row_c),
    .h_sync(hs_c), .v_sync(vs_c), .active_video(act_c), .screen_inactive(si_c),
    .frame_start(fs_c), .vblank_irq(vb_c), .frame_count(fc_c)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model state: enabled ticks since reset, and whether the last edge was an enabled tick.
  longint ticks = 0;
  bit     last_tick = 1'b0;

  task automatic check_unit(input string nm, input int ha, input int hf, input int hsw,
                            input int hb, input int va, input int vf, input int vsw,
                            input int vb, input bit hpol, input bit vpol, input int dly,
                            input int fw, input longint col, input longint row,
                            input bit hs, input bit vs, input bit act, input bit si,
                            input bit fs, input bit vbi, input longint fc);
    longint ht, vt, fl, tt, cc, rr;
    bit     e_hs, e_vs, e_act;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    fl = ht * vt;
    if (ticks >= dly) begin
      tt    = ticks - dly;
      cc    = tt % ht;
      rr    = (tt / ht) % vt;
      e_hs  = (cc >= ha + hf && cc < ha + hf + hsw) ? hpol : !hpol;
      e_vs  = (rr >= va + vf && rr < va + vf + vsw) ? vpol : !vpol;
      e_act = (cc < ha) && (rr < va);
    end else begin
      e_hs  = !hpol;
      e_vs  = !vpol;
      e_act = 1'b0;
    end
    cc = ticks % ht;
    rr = (ticks / ht) % vt;
    check_eq({nm, ".col"}, col, cc);
    check_eq({nm, ".row"}, row, rr);
    check_eq({nm, ".h_sync"}, hs, e_hs);
    check_eq({nm, ".v_sync"}, vs, e_vs);
    check_eq({nm, ".active"}, act, e_act);
    check_eq({nm, ".scr_inactive"}, si, rr >= va);
    check_eq({nm, ".frame_start"}, fs, last_tick && ticks > 0 && (ticks % fl) == 0);
    check_eq({nm, ".vblank_irq"}, vbi, last_tick && (ticks % fl) == va * ht);
    check_eq({nm, ".frame_count"}, fc, (ticks / fl) % (longint'(1) << fw));
  endtask

  // Apply inputs for one edge, advance the model, then sample 1 ns after the edge.
  task automatic step(input bit r, input bit e);
    rst = r;
    en  = e;
    @(posedge clk);
    if (r) begin
      ticks     = 0;
      last_tick = 1'b0;
    end else if (e) begin
      ticks++;
      last_tick = 1'b1;
    end else begin
      last_tick = 1'b0;
    end
    #1;
    check_unit("a", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2, 8,
               col_a, row_a, hs_a, vs_a, act_a, si_a, fs_a, vb_a, fc_a);
    check_unit("b", 8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b0, 0, 2,
               col_b, row_b, hs_b, vs_b, act_b, si_b, fs_b, vb_b, fc_b);
    check_unit("c", 6, 1, 2, 1, 3, 1, 1, 2, 1'b0, 1'b1, 3, 3,
               col_c, row_c, hs_c, vs_c, act_c, si_c, fs_c, vb_c, fc_c);
  endtask

  int first_low, lows, wrap_at, prev_col, evt0, evt1, fs_cnt, vb_cnt, fc_wrapped, prev_fc;

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);

    // Continuous enable on the default timing: hsync position, width and line period.
    first_low = -1;
    lows      = 0;
    wrap_at   = -1;
    for (int i = 0; i < 1700; i++) begin
      step(1'b0, 1'b1);
      if (row_a == 0 && !hs_a) begin
        if (first_low < 0) first_low = col_a;
        lows++;
      end
      if (col_a == 0 && wrap_at < 0) wrap_at = i + 1;
    end
    check_eq("a_hs_first_low_col", first_low, 658);
    check_eq("a_hs_low_width", lows, 96);
    check_eq("a_line_period", wrap_at, 800);

    // Enable toggling every clock doubles line period and sync width.
    step(1'b1, 1'b0);
    lows     = 0;
    evt0     = -1;
    evt1     = -1;
    prev_col = 0;
    for (int i = 0; i < 4000; i++) begin
      step(1'b0, (i % 2) == 0);
      if (row_a == 0 && !hs_a) lows++;
      if (col_a == 0 && prev_col != 0) begin
        if (evt0 < 0) evt0 = i;
        else if (evt1 < 0) evt1 = i;
      end
      prev_col = col_a;
    end
    check_eq("a_toggle_line_period", evt1 - evt0, 1600);
    check_eq("a_toggle_hs_width", lows, 192);

    // Four small frames: frame_start count, vblank count, 2-bit frame counter wrap.
    step(1'b1, 1'b0);
    fs_cnt     = 0;
    vb_cnt     = 0;
    fc_wrapped = 0;
    prev_fc    = 0;
    for (int i = 0; i < 480; i++) begin
      step(1'b0, 1'b1);
      if (fs_b) fs_cnt++;
      if (vb_b) begin
        vb_cnt++;
        check_eq("b_vblank_pos", {row_b, col_b}, {5'd4, 5'd0});
      end
      if (prev_fc == 3 && fc_b == 0) fc_wrapped++;
      prev_fc = fc_b;
    end
    check_eq("b_frame_pulses", fs_cnt, 4);
    check_eq("b_vblank_pulses", vb_cnt, 4);
    check_eq("b_fc_wrap_3_to_0", fc_wrapped, 1);

    // Reset mid-frame with enable high: restart at (0,0), no frame pulse, count cleared.
    for (int i = 0; i < 57; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check_eq("b_rst_mid_col", col_b, 0);
    check_eq("a_rst_mid_hs", hs_a, 1);
    step(1'b0, 1'b1);

    // Random enable with rare resets.
    for (int i = 0; i < 8000; i++) begin
      step($urandom_range(0, 1999) == 0, $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
